// File: rtl/order_ingress_pkg.sv
// Shared order-word layout and ingress constants for the order path.
// Field positions live only here; every consumer imports this package.
package order_ingress_pkg;

    localparam int          ORDER_BYTES = 4;
    localparam int          WORD_W      = 8 * ORDER_BYTES;
    localparam logic [15:0] ERR_SAT     = 16'hFFFF;

    // {Price[31:16], ID[15:8], Qty[7:0]}; side flags live in the ID byte
    localparam int PRICE_MSB  = 31;
    localparam int PRICE_LSB  = 16;
    localparam int ID_MSB     = 15;
    localparam int ID_LSB     = 8;
    localparam int QTY_MSB    = 7;
    localparam int QTY_LSB    = 0;
    localparam int IS_BUY_BIT = 15;
    localparam int IS_BOT_BIT = 14;

    typedef logic [WORD_W-1:0] order_word_t;

    function automatic logic [QTY_MSB-QTY_LSB:0] qty_of(input order_word_t w);
        return w[QTY_MSB:QTY_LSB];
    endfunction

endpackage

// File: rtl/order_fifo.sv
// Synchronous order-word FIFO with combinational head read and occupancy count.
// Shared with the trade report path, so it carries no order-specific logic.
module order_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    // Depth is a power of two, so the pointers wrap on their own
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/order_ingress.sv
// UDP payload bytes -> validated 32-bit order words -> FIFO -> paced one-at-a-time
// dispatch to matching_engine, with byte-level backpressure while the FIFO is full.
module order_ingress
    import order_ingress_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    s_data,
    input  logic                          s_valid,
    input  logic                          s_last,
    output logic                          s_ready,
    input  logic                          engine_busy,
    output logic                          input_valid,
    output logic [31:0]                   input_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   err_count,
    output logic [31:0]                   disp_count
);
    logic [1:0]  bi;
    logic [23:0] shreg;
    order_word_t word;
    order_word_t head;
    logic        accept;
    logic        complete;
    logic        runt;
    logic        zero_qty;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    logic        holdoff;

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == ERR_SAT) ? c : c + 16'd1;
    endfunction

    assign s_ready  = !full;
    assign accept   = s_valid && s_ready;
    assign word     = {shreg, s_data};
    assign complete = accept && (bi == 2'(ORDER_BYTES - 1));
    assign runt     = accept && s_last && !complete;
    assign zero_qty = complete && (qty_of(word) == '0);
    assign push     = complete && !zero_qty;
    // FIFO empty flag is registered, so a word pushed this edge pops no earlier than the next
    assign pop      = !empty && !engine_busy && !holdoff;

    order_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (word),
        .dout  (head),
        .level (fifo_level),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (accept)
            shreg <= {shreg[15:0], s_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bi          <= '0;
            err_count   <= '0;
            holdoff     <= 1'b0;
            input_valid <= 1'b0;
            input_data  <= '0;
            disp_count  <= '0;
        end else begin
            if (accept)
                bi <= (complete || runt) ? 2'd0 : bi + 2'd1;
            if (runt || zero_qty)
                err_count <= sat_inc(err_count);
            // holdoff masks the cycle before the engine's registered busy rises
            holdoff     <= pop;
            input_valid <= pop;
            if (pop) begin
                input_data <= head;
                disp_count <= disp_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_order_ingress.sv
// Scoreboard bench for order_ingress: packet-level reference model feeds an
// expected-word queue; an independent monitor checks every dispatch pulse.
`timescale 1ns/1ps
module tb_order_ingress;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    s_data = 8'h00;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic          s_ready;
    logic          engine_busy;
    logic          input_valid;
    logic [31:0]   input_data;
    logic [LW-1:0] fifo_level;
    logic [15:0]   err_count;
    logic [31:0]   disp_count;

    order_ingress #(.FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .engine_busy (engine_busy),
        .input_valid (input_valid),
        .input_data  (input_data),
        .fifo_level  (fifo_level),
        .err_count   (err_count),
        .disp_count  (disp_count)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] pkt[$];
    logic [7:0]  tail_q[$];
    int          exp_err = 0;
    int          exp_disp = 0;
    int          pulses = 0;
    int          cyc = 0;
    int          last_byte_cyc = 0;
    int          last_pulse_cyc = 0;
    logic        hold_busy = 1'b0;
    int          busy_len = 0;
    int          busy_cnt;
    logic        busy_at_edge = 1'b0;
    logic        valid_at_edge = 1'b0;
    bit          snd_done;

    // Engine model: registered busy for busy_len cycles after each accepted pulse
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            busy_cnt <= 0;
        else if (input_valid)
            busy_cnt <= busy_len;
        else if (busy_cnt != 0)
            busy_cnt <= busy_cnt - 1;
    end
    assign engine_busy = hold_busy || (busy_cnt != 0);

    always @(posedge clk) begin
        cyc           <= cyc + 1;
        busy_at_edge  <= engine_busy;
        valid_at_edge <= input_valid;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Monitor: every pulse must match the queue head and respect busy/holdoff
    always @(negedge clk) begin
        if (rst_n && input_valid) begin
            pulses++;
            last_pulse_cyc = cyc;
            chk("pulse_while_busy_or_holdoff", {30'd0, busy_at_edge, valid_at_edge}, 32'd0);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_pulse: got %h expected none", input_data);
            end else begin
                exp_disp++;
                chk("input_data", input_data, exp_q.pop_front());
                chk("disp_count", disp_count, 32'(exp_disp));
            end
        end
    end

    // Called at a negedge; returns at the negedge just after the accepting edge
    task automatic send_byte(input logic [7:0] b, input logic last);
        int n = 0;
        s_data  = b;
        s_valid = 1'b1;
        s_last  = last;
        while (!s_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) fail_now("byte_accept");
        last_byte_cyc = cyc;
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Packet model: whole words are checked for zero qty, a ragged tail is a runt
    task automatic send_packet(input bit gaps);
        logic [7:0] b[$];
        foreach (pkt[i]) begin
            if (pkt[i][7:0] == 8'h00) exp_err++;
            else exp_q.push_back(pkt[i]);
            for (int k = 3; k >= 0; k--) b.push_back(pkt[i][8*k +: 8]);
        end
        if (tail_q.size() != 0) exp_err++;
        foreach (tail_q[i]) b.push_back(tail_q[i]);
        foreach (b[i]) begin
            if (gaps && $urandom_range(0, 3) == 0) @(negedge clk);
            send_byte(b[i], i == b.size() - 1);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || fifo_level != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) fail_now("drain");
        repeat (12) @(negedge clk);
    endtask

    function automatic logic [31:0] rand_word(input bit allow_zero);
        logic [31:0] w = $urandom;
        if (allow_zero && $urandom_range(0, 5) == 0) w[7:0] = 8'h00;
        else if (w[7:0] == 8'h00) w[7:0] = 8'h01;
        return w;
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int acc;
        int n;
        logic [31:0] w3;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst_input_valid", 32'(input_valid), 32'd0);
        chk("rst_input_data", input_data, 32'd0);
        chk("rst_fifo_level", 32'(fifo_level), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_disp_count", disp_count, 32'd0);

        // Single order and minimum latency
        pkt = '{32'h0064000A};
        tail_q = {};
        send_packet(0);
        acc = last_byte_cyc;
        drain();
        chk("single_latency", 32'(last_pulse_cyc - acc), 32'd2);
        chk("single_disp_count", disp_count, 32'd1);
        chk("single_pulses", 32'(pulses), 32'd1);

        // Runt then zero quantity
        p0 = pulses;
        pkt = {};
        tail_q = '{8'h01, 8'h02, 8'h03};
        send_packet(0);
        pkt = '{32'h00C80000};
        tail_q = {};
        send_packet(0);
        repeat (8) @(negedge clk);
        chk("runt_zero_err_count", 32'(err_count), 32'd2);
        chk("runt_zero_model_err", 32'(exp_err), 32'd2);
        chk("runt_zero_no_pulse", 32'(pulses - p0), 32'd0);
        chk("runt_zero_fifo_level", 32'(fifo_level), 32'd0);

        // Busy pacing: three orders in one packet
        p0 = pulses;
        busy_len = 6;
        pkt = '{rand_word(0), rand_word(0), rand_word(0)};
        send_packet(0);
        drain();
        chk("pacing_pulses", 32'(pulses - p0), 32'd3);

        // Full backpressure with the engine held busy
        p0 = pulses;
        hold_busy = 1'b1;
        pkt = {};
        for (int i = 0; i < 6; i++) pkt.push_back(rand_word(0));
        snd_done = 0;
        fork
            begin
                send_packet(0);
                snd_done = 1;
            end
        join_none
        n = 0;
        while (fifo_level != LW'(DEPTH) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail_now("fill_fifo");
        chk("full_s_ready", 32'(s_ready), 32'd0);
        repeat (6) @(negedge clk);
        chk("full_level_held", 32'(fifo_level), 32'(DEPTH));
        chk("full_s_ready_held", 32'(s_ready), 32'd0);
        chk("full_no_pulse", 32'(pulses - p0), 32'd0);
        hold_busy = 1'b0;
        n = 0;
        while (!snd_done && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!snd_done) fail_now("full_sender");
        drain();
        chk("full_all_dispatched", 32'(pulses - p0), 32'd6);

        // Push and pop on the same edge with two words queued
        hold_busy = 1'b1;
        pkt = '{rand_word(0), rand_word(0)};
        send_packet(0);
        repeat (2) @(negedge clk);
        chk("simul_pre_level", 32'(fifo_level), 32'd2);
        w3 = rand_word(0);
        exp_q.push_back(w3);
        send_byte(w3[31:24], 1'b0);
        send_byte(w3[23:16], 1'b0);
        send_byte(w3[15:8], 1'b0);
        hold_busy = 1'b0;
        send_byte(w3[7:0], 1'b1);
        chk("simul_level", 32'(fifo_level), 32'd2);
        chk("simul_pulse", 32'(input_valid), 32'd1);
        drain();

        // Reset in the middle of a word
        busy_len = 0;
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        rst_n = 1'b0;
        exp_q.delete();
        exp_err = 0;
        exp_disp = 0;
        @(negedge clk);
        chk("midrst_fifo_level", 32'(fifo_level), 32'd0);
        chk("midrst_err_count", 32'(err_count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        p0 = pulses;
        pkt = '{32'h012C8005};
        tail_q = {};
        send_packet(0);
        drain();
        chk("midrst_pulses", 32'(pulses - p0), 32'd1);
        chk("midrst_err_after", 32'(err_count), 32'd0);
        chk("midrst_disp_after", disp_count, 32'd1);

        // Randomised packets, gaps, runts, zero qty and busy lengths
        for (int p = 0; p < 40; p++) begin
            busy_len = $urandom_range(0, 5);
            pkt = {};
            tail_q = {};
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) pkt.push_back(rand_word(1));
            if ($urandom_range(0, 4) == 0) begin
                n = $urandom_range(1, 3);
                for (int i = 0; i < n; i++) tail_q.push_back(8'($urandom));
            end
            send_packet(1);
        end
        drain();
        chk("rand_err_count", 32'(err_count), 32'(exp_err));
        chk("rand_disp_count", disp_count, 32'(exp_disp));
        chk("rand_fifo_level", 32'(fifo_level), 32'd0);
        chk("rand_s_ready", 32'(s_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
